// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: request/ack buses for ports A and B plus the shared ROM link
interface rom_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
);
    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_ack;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_req;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_ack;
    logic [DATA_WIDTH-1:0] b_data;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  busy;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, rom_data,
        output a_ack, a_data, b_ack, b_data, rom_addr, busy
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, rom_data,
        input  a_ack, a_data, b_ack, b_data, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous ROM between fetch (A) and data (B) ports
module rom_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 16,
    parameter int ROM_LATENCY = 1
) (
    input logic          clk,
    input logic          rst,
    rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT = 4'(ROM_LATENCY);

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner_b;
    logic                  r_last_b;
    logic [3:0]            r_lat_cnt;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [DATA_WIDTH-1:0] r_a_data;
    logic [DATA_WIDTH-1:0] r_b_data;
    logic                  r_a_ack;
    logic                  r_b_ack;
    logic                  w_grant;
    logic                  w_win_b;
    logic                  w_fire;

    assign w_grant = (r_state == IDLE) && (bus.a_req || bus.b_req);
    assign w_win_b = bus.b_req && (!bus.a_req || !r_last_b);
    assign w_fire  = (r_state == WAIT) && (r_lat_cnt == 4'd0);

    // next state: grant out of IDLE, leave WAIT when the latency count is spent, DONE lasts one cycle
    always_comb begin
        w_next = (r_state == IDLE) ? (w_grant ? WAIT : IDLE) :
                 (r_state == WAIT) ? (w_fire ? DONE : WAIT) : IDLE;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // grant bookkeeping: latch winner, its address and the latency countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_owner_b  <= 1'b0;
            r_last_b   <= 1'b1;
            r_lat_cnt  <= 4'd0;
        end else if (w_grant) begin
            r_rom_addr <= w_win_b ? bus.b_addr : bus.a_addr;
            r_owner_b  <= w_win_b;
            r_last_b   <= w_win_b;
            r_lat_cnt  <= LAT;
        end else if (r_state == WAIT && r_lat_cnt != 4'd0) begin
            r_lat_cnt  <= r_lat_cnt - 4'd1;
        end
    end

    // return path: only the owner's data register and ack change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_data <= '0;
            r_b_data <= '0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
        end else begin
            r_a_ack <= w_fire && !r_owner_b;
            r_b_ack <= w_fire && r_owner_b;
            if (w_fire && !r_owner_b) r_a_data <= bus.rom_data;
            if (w_fire && r_owner_b)  r_b_data <= bus.rom_data;
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.a_data   = r_a_data;
    assign bus.b_data   = r_b_data;
    assign bus.a_ack    = r_a_ack;
    assign bus.b_ack    = r_b_ack;
    assign bus.busy     = (r_state != IDLE);
endmodule
